// File: rtl/uart_tx_engine.sv
// uart_tx_engine
// ---------------------------------------------------------------------------
// UART transmit serializer. Pops bytes from the TX FIFO read port and shifts
// them onto the serial line as start bit, DATA_WIDTH data bits (LSB first),
// an optional parity bit and STOP_BITS stop bits. Single clock domain.
//
// Ports:
//   clk         in   clock (FIFO read clock)
//   rst         in   synchronous active-high reset
//   tx_en       in   allows new frames to start; a running frame always ends
//   fifo_empty  in   FIFO empty flag
//   fifo_rd_en  out  one-cycle FIFO read strobe per byte
//   fifo_rdata  in   FIFO read data, valid the cycle after fifo_rd_en
//   tx          out  serial line, idles high
//   busy        out  high while a frame is being fetched or sent
//   tx_done     out  one-cycle pulse on the last stop-bit cycle
//
// All outputs are registered from the current state, so they trail the
// internal state by one clock. The byte itself comes back from the FIFO one
// cycle after the registered strobe, which lands on the first START cycle;
// that is where the shift register and parity are loaded.
// ---------------------------------------------------------------------------
module uart_tx_engine #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_PARITY = 3'd5;
  localparam logic [2:0] S_STOP   = 3'd6;

  logic [2:0]            r_state;
  logic [2:0]            w_state_next;
  logic [BAUD_W-1:0]     r_baud;
  logic [BIT_W-1:0]      r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_parity;
  logic                  r_tx;
  logic                  r_rd_en;
  logic                  r_busy;
  logic                  r_done;

  logic w_go;
  logic w_baud_last;
  logic w_data_last;
  logic w_stop_last;
  logic w_timed;

  assign w_go        = tx_en && !fifo_empty;
  assign w_baud_last = (r_baud == BAUD_LAST);
  assign w_data_last = w_baud_last && (r_bit == DATA_LAST);
  // Stop phase reuses the bit counter to count stop bits.
  assign w_stop_last = w_baud_last && (r_bit == STOP_LAST);
  assign w_timed     = (r_state == S_START) || (r_state == S_DATA) ||
                       (r_state == S_PARITY) || (r_state == S_STOP);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_go) w_state_next = S_FETCH;
      S_FETCH:  w_state_next = S_LOAD;
      S_LOAD:   w_state_next = S_START;
      S_START:  if (w_baud_last) w_state_next = S_DATA;
      S_DATA:   if (w_data_last) w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_baud_last) w_state_next = S_STOP;
      S_STOP:   if (w_stop_last) w_state_next = w_go ? S_FETCH : S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
      r_rd_en  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if ((w_state_next != r_state) || w_baud_last)
        r_baud <= '0;
      else if (w_timed)
        r_baud <= r_baud + BAUD_W'(1);

      if (w_state_next != r_state)
        r_bit <= '0;
      else if (w_baud_last && ((r_state == S_DATA) || (r_state == S_STOP)))
        r_bit <= r_bit + BIT_W'(1);

      // Read data returns on the first START cycle; this is the only place
      // fifo_rdata is looked at, so later changes cannot disturb the frame.
      if ((r_state == S_START) && (r_baud == '0)) begin
        r_shift  <= fifo_rdata;
        r_parity <= (^fifo_rdata) ^ PAR_ODD;
      end else if ((r_state == S_DATA) && w_baud_last) begin
        r_shift <= r_shift >> 1;
      end

      case (r_state)
        S_START:  r_tx <= 1'b0;
        S_DATA:   r_tx <= r_shift[0];
        S_PARITY: r_tx <= r_parity;
        default:  r_tx <= 1'b1;
      endcase

      r_rd_en <= (r_state == S_FETCH);
      r_busy  <= (r_state != S_IDLE);
      r_done  <= (r_state == S_STOP) && w_stop_last;
    end
  end

  assign tx         = r_tx;
  assign fifo_rd_en = r_rd_en;
  assign busy       = r_busy;
  assign tx_done    = r_done;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Testbench for uart_tx_engine. One DUT without parity drives a small FIFO
// model; two parity DUTs (even / odd) share a static data word.
module tb_uart_tx_engine;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main DUT and its FIFO model
  logic       tx_en = 1'b1;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rdata = 8'h00;
  logic       tx, busy, tx_done;

  logic [7:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_rdata <= mem[rd_ptr % 16];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  // Parity DUTs
  logic       p_en = 1'b0;
  logic       p_empty = 1'b1;
  logic [7:0] p_rdata = 8'h00;
  logic       rd_e, rd_o, tx_e, tx_o, busy_e, busy_o, done_e, done_o;

  uart_tx_engine #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rdata(fifo_rdata), .tx(tx), .busy(busy), .tx_done(tx_done));

  uart_tx_engine #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
    .clk(clk), .rst(rst), .tx_en(p_en), .fifo_empty(p_empty), .fifo_rd_en(rd_e),
    .fifo_rdata(p_rdata), .tx(tx_e), .busy(busy_e), .tx_done(done_e));

  uart_tx_engine #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst(rst), .tx_en(p_en), .fifo_empty(p_empty), .fifo_rd_en(rd_o),
    .fifo_rdata(p_rdata), .tx(tx_o), .busy(busy_o), .tx_done(done_o));

  // Event monitors
  int rd_cnt = 0, done_cnt = 0, rd_empty_cnt = 0;
  int prd_cnt = 0, pdone_cnt = 0;
  always @(posedge clk) begin
    if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
    if (tx_done) done_cnt <= done_cnt + 1;
    if (fifo_rd_en && fifo_empty) rd_empty_cnt <= rd_empty_cnt + 1;
    if (rd_e && rd_o) prd_cnt <= prd_cnt + 1;
    if (done_e && done_o) pdone_cnt <= pdone_cnt + 1;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 16] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_low(input int sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (((sel == 0) ? tx : (sel == 1) ? tx_e : tx_o) === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Samples all three lines for nbits bit periods starting at the current
  // negedge (first start-bit cycle). Optionally drops tx_en at cycle drop_at.
  task automatic capture(input int nbits, input int drop_at,
                         output logic [15:0] fm, output logic [15:0] fe, output logic [15:0] fo,
                         output int glitches, output int done_idx, output int busy_lo);
    glitches = 0; done_idx = -1; busy_lo = 0;
    fm = '0; fe = '0; fo = '0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < CPB; c++) begin
        int idx;
        idx = b * CPB + c;
        if (idx == drop_at) tx_en = 1'b0;
        if (c == 0) begin
          fm[b] = tx; fe[b] = tx_e; fo[b] = tx_o;
        end else begin
          if (tx !== fm[b]) glitches++;
          if (tx_e !== fe[b]) glitches++;
          if (tx_o !== fo[b]) glitches++;
        end
        if (tx_done === 1'b1 && done_idx < 0) done_idx = idx;
        if (busy !== 1'b1) busy_lo++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; tx_en = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({tx, busy, fifo_rd_en, tx_done} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 1000", {tx, busy, fifo_rd_en, tx_done});
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if ({tx, busy, rd_cnt} !== {1'b1, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL idle_empty: tx=%b busy=%b rd_pulses=%0d expected tx=1 busy=0 rd_pulses=0", tx, busy, rd_cnt);
    end
    $display("reset/idle: tx=%b busy=%b rd_pulses=%0d", tx, busy, rd_cnt);
  endtask

  task automatic test_single;
    logic [15:0] fm, fe, fo;
    int gl, di, bl, r0, d0;
    r0 = rd_cnt; d0 = done_cnt;
    push(8'hA5);
    @(negedge clk);
    n_checks++;
    if ({fifo_rd_en, tx} !== 2'b01) begin
      n_fail++; $display("FAIL single_edge0: rd_en,tx=%b expected 01", {fifo_rd_en, tx});
    end
    @(negedge clk);
    n_checks++;
    if ({fifo_rd_en, busy} !== 2'b11) begin
      n_fail++; $display("FAIL single_edge1: rd_en,busy=%b expected 11", {fifo_rd_en, busy});
    end
    @(negedge clk);
    n_checks++;
    if ({fifo_rd_en, tx} !== 2'b01) begin
      n_fail++; $display("FAIL single_edge2: rd_en,tx=%b expected 01", {fifo_rd_en, tx});
    end
    @(negedge clk);
    n_checks++;
    if (tx !== 1'b0) begin
      n_fail++; $display("FAIL single_edge3: tx=%b expected 0", tx);
    end
    capture(10, -1, fm, fe, fo, gl, di, bl);
    n_checks++;
    if (fm[9:0] !== 10'h34A || gl != 0) begin
      n_fail++; $display("FAIL single_frame: got %h glitches=%0d expected 34a glitches=0", fm[9:0], gl);
    end
    n_checks++;
    if (di != 39 || bl != 0) begin
      n_fail++; $display("FAIL single_done_busy: done_idx=%0d busy_low=%0d expected 39 and 0", di, bl);
    end
    n_checks++;
    if ({busy, tx} !== 2'b01) begin
      n_fail++; $display("FAIL single_end: busy,tx=%b expected 01", {busy, tx});
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if ((rd_cnt - r0) != 1 || (done_cnt - d0) != 1) begin
      n_fail++; $display("FAIL single_counts: rd=%0d done=%0d expected 1 and 1", rd_cnt - r0, done_cnt - d0);
    end
    $display("single 0xA5: frame=%h done_idx=%0d", fm[9:0], di);
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp_f [3];
    logic [15:0] fm, fe, fo;
    logic [2:0] g, bz;
    int gl, di, bl, r0, d0;
    bit ok;
    exp_f = '{10'h200, 10'h3FE, 10'h278};
    r0 = rd_cnt; d0 = done_cnt;
    tx_en = 1'b0;
    push(8'h00); push(8'hFF); push(8'h3C);
    tx_en = 1'b1;
    wait_low(0, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL b2b_start: tx never fell");
    end
    for (int f = 0; f < 3; f++) begin
      capture(10, -1, fm, fe, fo, gl, di, bl);
      n_checks++;
      if (fm[9:0] !== exp_f[f] || gl != 0 || bl != 0) begin
        n_fail++; $display("FAIL b2b_frame%0d: got %h glitches=%0d busy_low=%0d expected %h 0 0", f, fm[9:0], gl, bl, exp_f[f]);
      end
      $display("b2b frame %0d: %h", f, fm[9:0]);
      if (f < 2) begin
        g[2] = tx; bz[2] = busy; @(negedge clk);
        g[1] = tx; bz[1] = busy; @(negedge clk);
        g[0] = tx; bz[0] = busy;
        n_checks++;
        if (g !== 3'b110 || bz !== 3'b111) begin
          n_fail++; $display("FAIL b2b_gap%0d: tx=%b busy=%b expected 110 111", f, g, bz);
        end
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: busy=%b expected 0", busy);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ((rd_cnt - r0) != 3 || (done_cnt - d0) != 3) begin
      n_fail++; $display("FAIL b2b_counts: rd=%0d done=%0d expected 3 and 3", rd_cnt - r0, done_cnt - d0);
    end
  endtask

  task automatic test_tx_en_drop;
    logic [15:0] fm, fe, fo;
    int gl, di, bl, r0, d0;
    bit ok;
    r0 = rd_cnt; d0 = done_cnt;
    tx_en = 1'b0;
    push(8'hA5); push(8'h3C);
    tx_en = 1'b1;
    wait_low(0, ok);
    capture(10, 12, fm, fe, fo, gl, di, bl);
    n_checks++;
    if (!ok || fm[9:0] !== 10'h34A || gl != 0) begin
      n_fail++; $display("FAIL drop_frame: got %h glitches=%0d expected 34a 0", fm[9:0], gl);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if ((rd_cnt - r0) != 1 || (done_cnt - d0) != 1 || busy !== 1'b0 || (wr_ptr - rd_ptr) != 1) begin
      n_fail++; $display("FAIL drop_stop: rd=%0d done=%0d busy=%b left=%0d expected 1 1 0 1",
                         rd_cnt - r0, done_cnt - d0, busy, wr_ptr - rd_ptr);
    end
    $display("tx_en drop: frame=%h rd=%0d left=%0d", fm[9:0], rd_cnt - r0, wr_ptr - rd_ptr);
  endtask

  task automatic test_reset_mid;
    logic [15:0] fm, fe, fo;
    int gl, di, bl, r0, d0;
    bit ok;
    r0 = rd_cnt; d0 = done_cnt;
    push(8'hFF);
    tx_en = 1'b1;
    wait_low(0, ok);
    repeat (17) @(negedge clk);   // inside data bit 3
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (!ok || {tx, busy, fifo_rd_en} !== 3'b100) begin
      n_fail++; $display("FAIL rst_mid: tx,busy,rd_en=%b expected 100", {tx, busy, fifo_rd_en});
    end
    rst = 1'b0;
    n_checks++;
    if ((done_cnt - d0) != 0 || (rd_cnt - r0) != 1) begin
      n_fail++; $display("FAIL rst_mid_counts: done=%0d rd=%0d expected 0 and 1", done_cnt - d0, rd_cnt - r0);
    end
    wait_low(0, ok);
    capture(10, -1, fm, fe, fo, gl, di, bl);
    n_checks++;
    if (!ok || fm[9:0] !== 10'h3FE || gl != 0) begin
      n_fail++; $display("FAIL rst_next_frame: got %h glitches=%0d expected 3fe 0", fm[9:0], gl);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ((done_cnt - d0) != 1 || (rd_cnt - r0) != 2 || rd_empty_cnt != 0) begin
      n_fail++; $display("FAIL rst_after_counts: done=%0d rd=%0d rd_while_empty=%0d expected 1 2 0",
                         done_cnt - d0, rd_cnt - r0, rd_empty_cnt);
    end
    $display("reset mid-frame: next frame=%h", fm[9:0]);
  endtask

  task automatic test_parity;
    logic [15:0] fm, fe, fo;
    int gl, di, bl;
    bit ok;
    tx_en = 1'b0;
    p_rdata = 8'hA5; p_empty = 1'b0; p_en = 1'b1;
    wait_low(1, ok);
    p_empty = 1'b1;
    capture(11, -1, fm, fe, fo, gl, di, bl);
    n_checks++;
    if (!ok || fe[10:0] !== 11'h54A || fo[10:0] !== 11'h74A || gl != 0) begin
      n_fail++; $display("FAIL parity_a5: even=%h odd=%h glitches=%0d expected 54a 74a 0", fe[10:0], fo[10:0], gl);
    end
    n_checks++;
    if ({tx_e, tx_o, busy_e, busy_o} !== 4'b1100) begin
      n_fail++; $display("FAIL parity_a5_len: tx_e,tx_o,busy_e,busy_o=%b expected 1100", {tx_e, tx_o, busy_e, busy_o});
    end
    $display("parity 0xA5: even=%h odd=%h", fe[10:0], fo[10:0]);
    p_rdata = 8'h01; p_empty = 1'b0;
    wait_low(1, ok);
    p_empty = 1'b1;
    capture(11, -1, fm, fe, fo, gl, di, bl);
    n_checks++;
    if (!ok || fe[10:0] !== 11'h602 || fo[10:0] !== 11'h402 || gl != 0) begin
      n_fail++; $display("FAIL parity_01: even=%h odd=%h glitches=%0d expected 602 402 0", fe[10:0], fo[10:0], gl);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (prd_cnt != 2 || pdone_cnt != 2) begin
      n_fail++; $display("FAIL parity_counts: rd=%0d done=%0d expected 2 and 2", prd_cnt, pdone_cnt);
    end
    $display("parity 0x01: even=%h odd=%h", fe[10:0], fo[10:0]);
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_tx_en_drop;
    test_reset_mid;
    test_parity;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
UART transmit serializer on the TX side of the controller. It is the consumer of the TX FIFO read port: it pulls bytes out of the FIFO and shifts them onto the serial line as start, data (LSB first), optional parity and stop bits. It runs entirely in the FIFO read clock domain, uses its own baud divider, and has no other clock crossings.

Parameters:
DATA_WIDTH, 8, data bits per frame; must match the FIFO width.
CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 2.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
clk  in  1  single clock; the FIFO read clock.
rst  in  1  synchronous, active-high reset.
tx_en  in  1  enables the start of new frames; a frame already in progress always completes.
fifo_empty  in  1  FIFO empty flag.
fifo_rd_en  out  1  FIFO read strobe; a one-cycle pulse per byte.
fifo_rdata  in  DATA_WIDTH  FIFO read data; valid in the cycle after fifo_rd_en.
tx  out  1  serial line, registered; idles high.
busy  out  1  high from FETCH through the end of STOP.
tx_done  out  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset: synchronous, active-high. All outputs are registered.
  - Reset values: tx=1, fifo_rd_en=0, busy=0, tx_done=0, state=IDLE, baud counter=0, bit counter=0, shift register=0.
- State machine. States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
  - IDLE: tx=1. Go to FETCH when tx_en=1 and fifo_empty=0.
  - FETCH: fifo_rd_en=1 for exactly this one cycle. Go to LOAD.
  - LOAD: capture fifo_rdata into the shift register. Compute parity as the XOR of the data bits, inverted when PARITY_ODD=1. Go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: shift out DATA_WIDTH bits, LSB first, each held for CLKS_PER_BIT cycles.
  - PARITY: tx=parity bit for CLKS_PER_BIT cycles. This state is skipped when PARITY_EN=0.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets to 0 on every state change. The bit counter width is clog2(DATA_WIDTH).
- Frame timing:
  - If the edge sampling tx_en=1 and fifo_empty=0 is edge 0, fifo_rd_en is high after edge 1 and tx falls low after edge 3.
  - Frame length on tx is exactly (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
- End of frame (last STOP cycle):
  - tx_done pulses high for one cycle.
  - If tx_en=1 and fifo_empty=0, go directly to FETCH; busy stays high and tx stays 1 for exactly 2 extra cycles (FETCH, LOAD) between frames.
  - Otherwise go to IDLE and busy drops.
- fifo_empty is sampled only in IDLE and in the last STOP cycle. fifo_rd_en is never asserted while fifo_empty=1.
- tx_en deasserted mid-frame: the current frame completes; no further FETCH.
- fifo_rdata is ignored outside LOAD. Changes to fifo_rdata mid-frame do not affect tx.
- rst asserted mid-frame: abort. tx=1 and busy=0 on the next edge, no tx_done pulse, and no further fifo_rd_en. A byte already popped is lost.

Test Plan:
- Reset and idle: assert rst for 2 cycles, fifo_empty=1, tx_en=1 -> tx=1, busy=0, fifo_rd_en never asserted.
- Single byte: CLKS_PER_BIT=4, fifo_rdata=0xA5, one byte available, tx_en=1 -> exactly one fifo_rd_en pulse. tx carries 0,1,0,1,0,0,1,0,1,1, each for 4 cycles (40 cycles total). tx_done pulses once on the last stop cycle.
- Back-to-back: three bytes 0x00, 0xFF, 0x3C queued -> 3 rd_en pulses, frames separated by exactly 2 idle-high cycles, busy high throughout, 3 tx_done pulses.
- Parity: PARITY_EN=1 with 0xA5 -> parity bit 0 when PARITY_ODD=0 and 1 when PARITY_ODD=1. Each frame is 11 bits; with 0x01, even parity gives a parity bit of 1.
- tx_en drop: deassert tx_en during DATA of byte 1 with byte 2 queued -> byte 1 completes, no second rd_en, returns to IDLE.
- Reset mid-frame: assert rst during bit 3 of the DATA phase -> tx=1 and busy=0 next cycle, no tx_done. After release, the next queued byte transmits normally.
